// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - retire-event capture FIFO: compacts commit lanes, timestamps, drains one per cycle
module retire_trace_buffer #(
  parameter int COMMIT_WIDTH = 4,
  parameter int SEQ_W        = 32,
  parameter int CYC_W        = 64,
  parameter int DEPTH        = 64,
  parameter int DROP_W       = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CYC_W-1:0]              cycle_i,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [COMMIT_WIDTH-1:0]       commit_valid_i,
  input  logic [COMMIT_WIDTH*SEQ_W-1:0] commit_seq_i,
  input  logic [COMMIT_WIDTH-1:0]       commit_cti_i,
  input  logic [COMMIT_WIDTH-1:0]       commit_mispred_i,
  output logic                          trace_valid_o,
  input  logic                          trace_ready_i,
  output logic [SEQ_W-1:0]              trace_seq_o,
  output logic [CYC_W-1:0]              trace_cyc_o,
  output logic                          trace_cti_o,
  output logic                          trace_mispred_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [DROP_W-1:0]             drop_cnt_o,
  output logic                          overflow_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = $clog2(COMMIT_WIDTH + 1);
  localparam int DS_W   = DROP_W + 1;

  logic [SEQ_W-1:0] memSeq [DEPTH];
  logic [CYC_W-1:0] memCyc [DEPTH];
  logic             memCti [DEPTH];
  logic             memMis [DEPTH];

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  countQ;
  logic [DROP_W-1:0] dropCnt;
  logic              overflow;

  logic [LANE_W-1:0] laneRank [COMMIT_WIDTH];
  logic [PTR_W-1:0]  laneSlot [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] laneWrite;
  logic [LANE_W-1:0] pushCnt;
  logic [CNT_W-1:0]  freeSpace, written, dropped;
  logic [DS_W-1:0]   dropSum;
  logic              pop;

  // Each valid lane's rank among valid lanes gives its slot offset from tail;
  // lanes ranked at or beyond the free space are the ones dropped.
  always_comb begin
    pushCnt   = '0;
    laneWrite = '0;
    freeSpace = CNT_W'(DEPTH) - countQ;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      laneRank[k] = pushCnt;
      laneSlot[k] = tail + PTR_W'(pushCnt);
      if (enable_i && commit_valid_i[k]) begin
        laneWrite[k] = (CNT_W'(pushCnt) < freeSpace);
        pushCnt      = pushCnt + LANE_W'(1);
      end
    end
    written = (CNT_W'(pushCnt) > freeSpace) ? freeSpace : CNT_W'(pushCnt);
    dropped = CNT_W'(pushCnt) - written;
    dropSum = {1'b0, dropCnt} + DS_W'(dropped);
    pop     = (countQ != '0) && trace_ready_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      countQ   <= '0;
      dropCnt  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        memSeq[i] <= '0;
        memCyc[i] <= '0;
        memCti[i] <= 1'b0;
        memMis[i] <= 1'b0;
      end
    end else if (clear_i) begin
      head     <= '0;
      tail     <= '0;
      countQ   <= '0;
      dropCnt  <= '0;
      overflow <= 1'b0;
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (laneWrite[k]) begin
          memSeq[laneSlot[k]] <= commit_seq_i[k*SEQ_W +: SEQ_W];
          memCyc[laneSlot[k]] <= cycle_i;
          memCti[laneSlot[k]] <= commit_cti_i[k];
          memMis[laneSlot[k]] <= commit_mispred_i[k];
        end
      end
      tail   <= tail + PTR_W'(written);
      head   <= head + PTR_W'(pop);
      countQ <= countQ + written - CNT_W'(pop);
      if (dropped != '0) begin
        overflow <= 1'b1;
        dropCnt  <= dropSum[DROP_W] ? '1 : dropSum[DROP_W-1:0];
      end
    end
  end

  assign trace_valid_o   = (countQ != '0);
  assign trace_seq_o     = memSeq[head];
  assign trace_cyc_o     = memCyc[head];
  assign trace_cti_o     = memCti[head];
  assign trace_mispred_o = memMis[head];
  assign count_o         = countQ;
  assign drop_cnt_o      = dropCnt;
  assign overflow_o      = overflow;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - randomized bench for retire_trace_buffer against a queue model
module tb_retire_trace_buffer;
  localparam int CW = 4, SEQ_W = 32, CYC_W = 64, DEPTH = 64, DROP_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [CYC_W-1:0]  cycle_i;
  logic              enable_i, clear_i, trace_ready_i;
  logic [CW-1:0]     commit_valid_i, commit_cti_i, commit_mispred_i;
  logic [CW*SEQ_W-1:0] commit_seq_i;
  logic              trace_valid_o, trace_cti_o, trace_mispred_o, overflow_o;
  logic [SEQ_W-1:0]  trace_seq_o;
  logic [CYC_W-1:0]  trace_cyc_o;
  logic [6:0]        count_o;
  logic [DROP_W-1:0] drop_cnt_o;

  retire_trace_buffer dut (
    .clk(clk), .reset_n(reset_n), .cycle_i(cycle_i), .enable_i(enable_i), .clear_i(clear_i),
    .commit_valid_i(commit_valid_i), .commit_seq_i(commit_seq_i), .commit_cti_i(commit_cti_i),
    .commit_mispred_i(commit_mispred_i), .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i), .trace_seq_o(trace_seq_o), .trace_cyc_o(trace_cyc_o),
    .trace_cti_o(trace_cti_o), .trace_mispred_o(trace_mispred_o), .count_o(count_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  typedef struct packed {
    logic [63:0] cyc;
    logic [31:0] seq;
    logic        cti;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  longint      mDrop;
  bit          mOvf;
  int          total = 0;
  int          bad = 0;
  logic [31:0] seqGen = 32'h1000;
  logic [63:0] cyc = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compareAll();
    chk("valid", {63'd0, trace_valid_o}, {63'd0, mq.size() != 0});
    chk("count", {57'd0, count_o}, 64'(mq.size()));
    chk("drop", {32'd0, drop_cnt_o}, 64'(mDrop));
    chk("ovf", {63'd0, overflow_o}, {63'd0, mOvf});
    if (mq.size() != 0) begin
      chk("seq", {32'd0, trace_seq_o}, {32'd0, mq[0].seq});
      chk("cyc", trace_cyc_o, mq[0].cyc);
      chk("cti", {63'd0, trace_cti_o}, {63'd0, mq[0].cti});
      chk("mis", {63'd0, trace_mispred_o}, {63'd0, mq[0].mis});
    end
  endtask

  // Drives one cycle of inputs at the falling edge, advances the model, and checks after the edge.
  task automatic step(input bit en, input bit clr, input logic [3:0] v, input bit rdy,
                      input logic [127:0] seqs, input bit useSeqs);
    ent_t nw[$];
    int   free, wr, dr;
    bit   pop;
    enable_i       = en;
    clear_i        = clr;
    commit_valid_i = v;
    trace_ready_i  = rdy;
    cycle_i        = cyc;
    commit_cti_i     = 4'($urandom);
    commit_mispred_i = 4'($urandom);
    for (int k = 0; k < CW; k++) begin
      if (useSeqs) commit_seq_i[k*32 +: 32] = seqs[k*32 +: 32];
      else if (v[k]) begin
        commit_seq_i[k*32 +: 32] = seqGen;
        seqGen++;
      end else commit_seq_i[k*32 +: 32] = $urandom;
    end
    if (clr) begin
      mq.delete();
      mDrop = 0;
      mOvf  = 0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      free = DEPTH - mq.size();
      if (en)
        for (int k = 0; k < CW; k++)
          if (v[k]) nw.push_back('{cyc, commit_seq_i[k*32 +: 32], commit_cti_i[k], commit_mispred_i[k]});
      wr = (nw.size() > free) ? free : nw.size();
      dr = nw.size() - wr;
      if (dr > 0) begin
        mOvf  = 1;
        mDrop = (mDrop + dr > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mDrop + dr;
      end
      if (pop) void'(mq.pop_front());
      for (int i = 0; i < wr; i++) mq.push_back(nw[i]);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compareAll();
  endtask

  task automatic stepR(input bit en, input bit clr, input logic [3:0] v, input bit rdy);
    step(en, clr, v, rdy, 128'd0, 1'b0);
  endtask

  initial begin
    int pushed;
    logic [127:0] s;
    reset_n = 1'b0;
    enable_i = 1'b1; clear_i = 1'b0; commit_valid_i = 4'hF; trace_ready_i = 1'b0;
    cycle_i = '0; commit_seq_i = '1; commit_cti_i = 4'hF; commit_mispred_i = 4'hF;
    mDrop = 0; mOvf = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, trace_valid_o}, 64'd0);
    chk("rst_count", {57'd0, count_o}, 64'd0);
    chk("rst_drop", {32'd0, drop_cnt_o}, 64'd0);
    chk("rst_ovf", {63'd0, overflow_o}, 64'd0);
    chk("rst_seq", {32'd0, trace_seq_o}, 64'd0);
    chk("rst_cyc", trace_cyc_o, 64'd0);
    chk("rst_flags", {62'd0, trace_cti_o, trace_mispred_o}, 64'd0);
    reset_n = 1'b1;
    commit_valid_i = 4'h0;
    @(negedge clk);
    chk("rel_count", {57'd0, count_o}, 64'd0);

    // compaction
    cyc = 64'd10;
    s = '0;
    s[63:32]   = 32'h21;
    s[127:96]  = 32'h23;
    step(1, 0, 4'b1010, 1, s, 1);
    chk("cmp_seq0", {32'd0, trace_seq_o}, 64'h21);
    chk("cmp_cyc0", trace_cyc_o, 64'd10);
    stepR(1, 0, 4'b0000, 1);
    chk("cmp_seq1", {32'd0, trace_seq_o}, 64'h23);
    chk("cmp_cyc1", trace_cyc_o, 64'd10);
    stepR(1, 0, 4'b0000, 1);
    chk("cmp_empty", {63'd0, trace_valid_o}, 64'd0);

    // overflow then partial fit
    repeat (17) stepR(1, 0, 4'hF, 0);
    chk("ovf_count", {57'd0, count_o}, 64'd64);
    chk("ovf_drop", {32'd0, drop_cnt_o}, 64'd4);
    chk("ovf_flag", {63'd0, overflow_o}, 64'd1);
    repeat (2) stepR(0, 0, 4'hF, 1);
    chk("pf_count62", {57'd0, count_o}, 64'd62);
    stepR(1, 0, 4'hF, 1);
    chk("pf_count63", {57'd0, count_o}, 64'd63);
    chk("pf_drop", {32'd0, drop_cnt_o}, 64'd6);
    repeat (70) stepR(0, 0, 4'h0, 1);

    // backpressure across pointer wrap
    pushed = 0;
    for (int i = 0; pushed < 200; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(1, 15));
      pushed += $countones(v);
      stepR(1, 0, v, i[0]);
    end
    repeat (130) stepR(0, 0, 4'h0, 1);

    // clear with overflow pending, then disable
    repeat (20) stepR(1, 0, 4'hF, 0);
    stepR(1, 1, 4'hF, 1);
    chk("clr_count", {57'd0, count_o}, 64'd0);
    chk("clr_drop", {32'd0, drop_cnt_o}, 64'd0);
    chk("clr_ovf", {63'd0, overflow_o}, 64'd0);
    chk("clr_valid", {63'd0, trace_valid_o}, 64'd0);
    stepR(1, 0, 4'b0110, 0);
    stepR(0, 0, 4'hF, 0);
    chk("dis_count", {57'd0, count_o}, 64'd2);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      stepR($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0, 4'($urandom), $urandom_range(0, 2) != 0);

    // reset mid-drain
    repeat (10) stepR(1, 0, 4'hF, 0);
    reset_n = 1'b0;
    #1;
    chk("mrst_count", {57'd0, count_o}, 64'd0);
    chk("mrst_valid", {63'd0, trace_valid_o}, 64'd0);
    chk("mrst_seq", {32'd0, trace_seq_o}, 64'd0);
    mq.delete(); mDrop = 0; mOvf = 0;
    commit_valid_i = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    compareAll();
    for (int i = 0; i < 100; i++) stepR(1, 0, 4'($urandom), $urandom_range(0, 1) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
